conv_mix_nb: RTL and testbench
==============================

# conv_mix_nb

Parametrised successor of the six-lane binary-weight convolution mixer: N independent lanes, each multiplying a streamed DW-bit signed pixel by its own serially loaded K-tap ±1 kernel and accumulating into an AW-bit partial sum. It sits between the sliding-window unit (source of `din`) and the pooling/activation stage (sink of `dout`). Compared with the fixed six-lane version it adds:
- a valid/ready handshake on both input and output;
- per-window clear/emit modes, for summing across input channels;
- saturating output with a per-lane flag.

## Interface
Parameters:
- N, 6, number of lanes
- DW, 16, input pixel width (signed)
- K, 25, taps per window (kernel bits per lane)
- AW, 24, accumulator width (signed); must be ≥ DW+clog2(K)+1
- OW, 16, output width (signed, saturated)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- w_en  in  N  per-lane kernel shift enable
- w_bit  in  1  kernel bit shared by all lanes (1 → +1, 0 → −1)
- start  in  1  begin a window, sampled only in IDLE
- mode  in  2  latched on start; bit0 = clear accumulators first, bit1 = emit result at end
- din_valid  in  1  input tap valid
- din_ready  out  1  block accepts a tap
- din  in  N*DW  packed lane pixels, lane i at [i*DW +: DW]
- dout_valid  out  1  result valid
- dout_ready  in  1  sink accepts result
- dout  out  N*OW  packed saturated results
- sat  out  N  per-lane saturation flag, qualified by dout_valid
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at window completion

## Operation
- Kernel load (IDLE only): each cycle with w_en[i]=1, kern_i <= {kern_i[K-2:0], w_bit}. The first bit loaded after K shifts is kern_i[K-1], used by tap 0. Tap t uses kern_i[K-1-t]. w_en is ignored outside IDLE.
- FSM states: IDLE, RUN, OUT.
  - IDLE: din_ready=0. If start=1, latch mode, tap_cnt<=0, clear all acc if mode[0]=1, then go to RUN. If start and w_en arrive in the same cycle, both take effect: start wins for the state change, and the shift still happens this cycle.
  - RUN: din_ready=1. On each din_valid&din_ready: acc_i <= acc_i + (kern_i[K-1-tap_cnt] ? din_i : −din_i), with sign extension to AW, and tap_cnt++. On the accepted tap with tap_cnt==K-1:
    - if emit=1, go to OUT;
    - otherwise go to IDLE and pulse done.
  - OUT: dout_valid=1, and dout/sat are held stable. On dout_ready=1, go to IDLE and pulse done.
- Accumulator arithmetic: two's-complement, wraps at AW bits. Overflow is the integrator's problem, bounded by the AW parameter rule.
- Output saturation: if acc_i > 2^(OW-1)−1, dout_i = 2^(OW-1)−1 and sat_i=1. If acc_i < −2^(OW-1), dout_i = −2^(OW-1) and sat_i=1. Otherwise dout_i = acc_i[OW-1:0] and sat_i=0.
- Chaining: a window with mode=01 (clear, no emit) followed by windows with mode=00 or mode=10 sums across input channels. Accumulators persist in IDLE.
- start is ignored in RUN and OUT. din_valid is ignored outside RUN.

## Timing
- Reset values: state=IDLE, acc=0, kern=0, tap_cnt=0, mode latch=0. Outputs reset to din_ready=0, dout_valid=0, dout=0, sat=0, busy=0, done=0.
- rst asserted in any state (including mid-RUN or OUT) returns the block to IDLE the next cycle. The partial window is discarded and no done pulse is produced.
- start at cycle c gives busy=1 and din_ready=1 at c+1.
- With din_valid held high, K taps are accepted at c+1 … c+K.
- If emit=1: dout_valid=1 at c+K+1. dout is registered from the final accumulator, so it has no combinational path from din.
- If emit=0: done=1 at c+K+1, and the block is in IDLE at c+K+1.
- In OUT: a handshake at cycle h gives done=1, dout_valid=0 and IDLE at h+1. A new start can be sampled at h+1.
- Minimum window period with emit=1 and dout_ready held high: K+2 cycles.

## Test plan
Parameters N=2, DW=16, K=4, AW=24, OW=16 for all scenarios.
- Basic window: load lane0 kernel 1111 (w_en=01) and lane1 kernel 1010 (w_en=10); start with mode=11; feed lane0 and lane1 pixels 1,2,3,4. Required: dout0=10 and dout1=1−2+3−4=−2, with dout_valid at start+5.
- Chained windows: first window mode=01 with pixels 1,1,1,1; second window mode=10 with pixels 2,2,2,2; lane0 kernel 1111. Required: a single result with dout0=12, and done pulses after both windows.
- Saturation: lane0 kernel 1111, lane1 kernel 0000, all pixels 30000. Required: dout0=32767 with sat[0]=1, and dout1=−32768 with sat[1]=1.
- Backpressure: hold dout_ready=0 for 5 cycles in OUT while pulsing start and w_en. Required: dout stable, din_ready=0, kernels unchanged, start ignored; on dout_ready=1, done pulses exactly once.
- Bubbles and reset: insert din_valid gaps of 0–3 cycles. Required: the same result as the no-gap case. Then assert rst after 2 taps. Required: IDLE next cycle, no dout_valid, no done, acc=0.
- Load during RUN: toggle w_en mid-window. Required: the result uses the pre-window kernels.

Source files
------------

// File: rtl/conv_mix_nb.sv
// N-lane binary-weight (+1/-1) convolution mixer with valid/ready handshakes,
// per-window clear/emit modes and saturating per-lane outputs.

module conv_mix_nb_lane #(
   parameter int DW = 16,
   parameter int K  = 25,
   parameter int AW = 24,
   parameter int OW = 16,
   parameter int TW = 5
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_shift,
   input  logic                 i_w_bit,
   input  logic                 i_clr,
   input  logic                 i_acc_en,
   input  logic                 i_cap,
   input  logic [TW-1:0]        i_tap,
   input  logic signed [DW-1:0] i_din,
   output logic signed [OW-1:0] o_dout,
   output logic                 o_sat
);
   localparam logic [TW-1:0]        LAST = TW'(K-1);
   localparam logic signed [AW-1:0] SMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [AW-1:0] SMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   logic [K-1:0]        r_kern;
   logic signed [AW-1:0] r_acc;
   logic signed [AW-1:0] w_ext, w_term, w_nxt;
   logic                 w_kbit;

   // Tap 0 uses the oldest loaded bit, which has shifted up to the MSB.
   assign w_kbit = r_kern[LAST - i_tap];
   assign w_ext  = {{(AW-DW){i_din[DW-1]}}, i_din};
   assign w_term = w_kbit ? w_ext : -w_ext;
   assign w_nxt  = r_acc + w_term;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_kern <= '0;
         r_acc  <= '0;
         o_dout <= '0;
         o_sat  <= 1'b0;
      end else begin
         if (i_shift)
            r_kern <= {r_kern[K-2:0], i_w_bit};
         if (i_clr)
            r_acc <= '0;
         else if (i_acc_en)
            r_acc <= w_nxt;
         // Result is captured from the final sum so dout never sees din combinationally.
         if (i_cap) begin
            if (w_nxt > SMAX) begin
               o_dout <= SMAX[OW-1:0];
               o_sat  <= 1'b1;
            end else if (w_nxt < SMIN) begin
               o_dout <= SMIN[OW-1:0];
               o_sat  <= 1'b1;
            end else begin
               o_dout <= w_nxt[OW-1:0];
               o_sat  <= 1'b0;
            end
         end
      end
   end
endmodule

module conv_mix_nb #(
   parameter int N  = 6,
   parameter int DW = 16,
   parameter int K  = 25,
   parameter int AW = 24,
   parameter int OW = 16
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [N-1:0]    i_w_en,
   input  logic            i_w_bit,
   input  logic            i_start,
   input  logic [1:0]      i_mode,
   input  logic            i_din_valid,
   output logic            o_din_ready,
   input  logic [N*DW-1:0] i_din,
   output logic            o_dout_valid,
   input  logic            i_dout_ready,
   output logic [N*OW-1:0] o_dout,
   output logic [N-1:0]    o_sat,
   output logic            o_busy,
   output logic            o_done
);
   localparam int TW = (K > 1) ? $clog2(K) : 1;
   localparam logic [TW-1:0] LAST = TW'(K-1);

   typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

   state_t        r_state;
   logic [TW-1:0] r_tap;
   logic          r_emit;

   logic w_idle, w_acc_en, w_last, w_cap, w_clr;

   assign w_idle   = (r_state == IDLE);
   assign w_acc_en = o_din_ready & i_din_valid;
   assign w_last   = w_acc_en & (r_tap == LAST);
   assign w_cap    = w_last & r_emit;
   assign w_clr    = w_idle & i_start & i_mode[0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_tap        <= '0;
         r_emit       <= 1'b0;
         o_din_ready  <= 1'b0;
         o_dout_valid <= 1'b0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            IDLE: if (i_start) begin
               r_emit      <= i_mode[1];
               r_tap       <= '0;
               r_state     <= RUN;
               o_din_ready <= 1'b1;
               o_busy      <= 1'b1;
            end
            RUN: if (w_acc_en) begin
               r_tap <= r_tap + 1'b1;
               if (w_last) begin
                  r_tap       <= '0;
                  o_din_ready <= 1'b0;
                  if (r_emit) begin
                     r_state      <= OUT;
                     o_dout_valid <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                     o_busy  <= 1'b0;
                     o_done  <= 1'b1;
                  end
               end
            end
            OUT: if (i_dout_ready) begin
               r_state      <= IDLE;
               o_dout_valid <= 1'b0;
               o_busy       <= 1'b0;
               o_done       <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_lane
      conv_mix_nb_lane #(.DW(DW), .K(K), .AW(AW), .OW(OW), .TW(TW)) u_lane (
         .i_clk    (i_clk),
         .i_rst    (i_rst),
         .i_shift  (w_idle & i_w_en[g]),
         .i_w_bit  (i_w_bit),
         .i_clr    (w_clr),
         .i_acc_en (w_acc_en),
         .i_cap    (w_cap),
         .i_tap    (r_tap),
         .i_din    (i_din[g*DW +: DW]),
         .o_dout   (o_dout[g*OW +: OW]),
         .o_sat    (o_sat[g])
      );
   end
endmodule

// File: tb/tb_conv_mix_nb.sv
// Bench for conv_mix_nb (N=2, K=4): directed vector table, corner sequences,
// and random windows checked against a queue-based kernel/sum model.

module tb_conv_mix_nb;
   logic        clk = 1'b0;
   logic        rst, w_bit, start, din_valid, dout_ready;
   logic [1:0]  w_en, mode;
   logic [31:0] din;
   logic        din_ready, dout_valid, busy, done;
   logic [31:0] dout;
   logic [1:0]  sat;

   conv_mix_nb #(.N(2), .DW(16), .K(4), .AW(24), .OW(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_w_en(w_en), .i_w_bit(w_bit), .i_start(start),
      .i_mode(mode), .i_din_valid(din_valid), .o_din_ready(din_ready), .i_din(din),
      .o_dout_valid(dout_valid), .i_dout_ready(dout_ready), .o_dout(dout),
      .o_sat(sat), .o_busy(busy), .o_done(done));

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   int mk[2][$];          // loaded kernel bits per lane, oldest (tap 0) first
   longint macc[2];

   typedef struct {
      logic [3:0] k0, k1;
      logic [1:0] md;
      int p0[4];
      int p1[4];
      int x0, x1;
      logic [1:0] xs;
   } vec_t;
   vec_t tv[5];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic longint wrapa(input longint v);
      longint m = v & 64'hFFFFFF;
      if (m >= 64'h800000) m -= 64'h1000000;
      return m;
   endfunction

   function automatic longint clampo(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic model_reset();
      for (int l = 0; l < 2; l++) begin
         mk[l] = {0, 0, 0, 0};
         macc[l] = 0;
      end
   endtask

   // kb[3] is loaded first and becomes tap 0
   task automatic load(input logic [1:0] mask, input logic [3:0] kb);
      for (int t = 0; t < 4; t++) begin
         w_en = mask;
         w_bit = kb[3-t];
         for (int l = 0; l < 2; l++)
            if (mask[l]) begin
               mk[l].push_back(int'(kb[3-t]));
               void'(mk[l].pop_front());
            end
         tick();
      end
      w_en = 2'b00;
   endtask

   task automatic run_win(input logic [1:0] md, input int p0[4], input int p1[4],
                          input int maxgap, input int rdy_delay, input bit bp, input bit midload,
                          output longint a0, output longint a1, output logic [1:0] as,
                          output longint e0, output longint e1, output logic [1:0] es);
      longint pv;
      mode = md;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("din_ready_after_start", din_ready, 1);
      if (md[0]) begin macc[0] = 0; macc[1] = 0; end
      for (int t = 0; t < 4; t++) begin
         if (maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
         din = {16'(p1[t]), 16'(p0[t])};
         din_valid = 1'b1;
         if (midload && t == 2) begin w_en = 2'b11; w_bit = 1'b1; end
         for (int l = 0; l < 2; l++) begin
            pv = (l == 0) ? longint'(p0[t]) : longint'(p1[t]);
            macc[l] = wrapa(macc[l] + ((mk[l][t] != 0) ? pv : -pv));
         end
         tick();
         din_valid = 1'b0;
         w_en = 2'b00;
      end
      e0 = clampo(macc[0]);
      e1 = clampo(macc[1]);
      es = {e1 != macc[1], e0 != macc[0]};
      a0 = 0; a1 = 0; as = 2'b00;
      if (md[1]) begin
         chk("dout_valid_after_last_tap", dout_valid, 1);
         chk("no_done_before_handshake", done, 0);
         a0 = longint'($signed(dout[15:0]));
         a1 = longint'($signed(dout[31:16]));
         as = sat;
         for (int k = 0; k < rdy_delay; k++) begin
            if (bp) begin start = 1'b1; w_en = 2'b11; w_bit = 1'($urandom); end
            tick();
            start = 1'b0;
            w_en = 2'b00;
            if (bp) begin
               chk("bp_dout0_stable", longint'($signed(dout[15:0])), a0);
               chk("bp_dout1_stable", longint'($signed(dout[31:16])), a1);
               chk("bp_din_ready", din_ready, 0);
               chk("bp_dout_valid", dout_valid, 1);
               chk("bp_done", done, 0);
            end
         end
         dout_ready = 1'b1;
         tick();
         dout_ready = 1'b0;
         chk("done_after_handshake", done, 1);
         chk("dout_valid_cleared", dout_valid, 0);
         chk("idle_after_handshake", busy, 0);
      end else begin
         chk("done_no_emit", done, 1);
         chk("idle_no_emit", busy, 0);
         chk("no_dout_valid_no_emit", dout_valid, 0);
      end
      tick();
      chk("done_single_pulse", done, 0);
   endtask

   initial begin
      longint a0, a1, e0, e1;
      logic [1:0] as, es, md;
      int r0[4], r1[4];

      tv[0] = '{4'b1111, 4'b1010, 2'b11, '{1, 2, 3, 4}, '{1, 2, 3, 4}, 10, -2, 2'b00};
      tv[1] = '{4'b1111, 4'b0000, 2'b11, '{30000, 30000, 30000, 30000},
                '{30000, 30000, 30000, 30000}, 32767, -32768, 2'b11};
      tv[2] = '{4'b0110, 4'b1001, 2'b11, '{100, -200, 300, -400},
                '{-32768, -32768, -32768, -32768}, 400, 0, 2'b00};
      tv[3] = '{4'b1111, 4'b0000, 2'b11, '{8191, 8192, 8192, 8192},
                '{8192, 8192, 8192, 8192}, 32767, -32768, 2'b00};
      tv[4] = '{4'b1111, 4'b0000, 2'b11, '{8192, 8192, 8192, 8192},
                '{8192, 8192, 8192, 8193}, 32767, -32768, 2'b11};

      rst = 1'b1; w_en = 2'b00; w_bit = 1'b0; start = 1'b0; mode = 2'b00;
      din_valid = 1'b0; din = '0; dout_ready = 1'b0;
      model_reset();
      tick(); tick();
      chk("rst_din_ready", din_ready, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_sat", sat, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) begin
         load(2'b01, tv[i].k0);
         load(2'b10, tv[i].k1);
         run_win(tv[i].md, tv[i].p0, tv[i].p1, 0, i, 1'b0, 1'b0, a0, a1, as, e0, e1, es);
         chk($sformatf("vec%0d_dout0", i), a0, tv[i].x0);
         chk($sformatf("vec%0d_dout1", i), a1, tv[i].x1);
         chk($sformatf("vec%0d_sat", i), as, tv[i].xs);
      end

      // chained windows: clear without emit, then accumulate and emit
      load(2'b01, 4'b1111);
      load(2'b10, 4'b1100);
      run_win(2'b01, '{1, 1, 1, 1}, '{1, 2, 3, 4}, 0, 0, 1'b0, 1'b0, a0, a1, as, e0, e1, es);
      run_win(2'b10, '{2, 2, 2, 2}, '{10, 0, 0, 0}, 0, 1, 1'b0, 1'b0, a0, a1, as, e0, e1, es);
      chk("chain_dout0", a0, 12);
      chk("chain_dout1", a1, 6);

      // backpressure with start/w_en pulses in OUT, then kernels must be intact
      run_win(2'b11, '{5, 6, 7, 8}, '{5, 6, 7, 8}, 0, 5, 1'b1, 1'b0, a0, a1, as, e0, e1, es);
      chk("bp_dout0", a0, 26);
      chk("bp_dout1", a1, -4);
      chk("bp_start_ignored", busy, 0);
      run_win(2'b11, '{1, 2, 3, 4}, '{1, 2, 3, 4}, 0, 0, 1'b0, 1'b0, a0, a1, as, e0, e1, es);
      chk("kern_kept_dout0", a0, 10);
      chk("kern_kept_dout1", a1, -4);

      // bubbles: same result as gap-free case
      run_win(2'b11, '{1, 2, 3, 4}, '{1, 2, 3, 4}, 3, 0, 1'b0, 1'b0, a0, a1, as, e0, e1, es);
      chk("gap_dout0", a0, 10);
      chk("gap_dout1", a1, -4);

      // reset after two taps
      mode = 2'b11; start = 1'b1; tick(); start = 1'b0;
      for (int t = 0; t < 2; t++) begin
         din = {16'(7), 16'(9)}; din_valid = 1'b1; tick();
      end
      din_valid = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      model_reset();
      chk("mrst_busy", busy, 0);
      chk("mrst_din_ready", din_ready, 0);
      chk("mrst_dout_valid", dout_valid, 0);
      chk("mrst_done", done, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mrst_no_done", done, 0);
         chk("mrst_no_dout_valid", dout_valid, 0);
      end
      run_win(2'b10, '{1, 2, 3, 4}, '{5, 5, 5, 5}, 0, 0, 1'b0, 1'b0, a0, a1, as, e0, e1, es);
      chk("mrst_acc_zero_dout0", a0, -10);
      chk("mrst_acc_zero_dout1", a1, -20);

      // w_en toggled mid-window must not disturb the kernels in use
      load(2'b01, 4'b0101);
      load(2'b10, 4'b0011);
      run_win(2'b11, '{1, 2, 3, 4}, '{1, 2, 3, 4}, 0, 0, 1'b0, 1'b1, a0, a1, as, e0, e1, es);
      chk("midload_dout0", a0, 2);
      chk("midload_dout1", a1, 4);

      // random windows against the model
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 1)
            load(2'($urandom_range(1, 3)), 4'($urandom));
         md = 2'($urandom);
         for (int t = 0; t < 4; t++) begin
            r0[t] = int'($urandom_range(0, 65535)) - 32768;
            r1[t] = int'($urandom_range(0, 65535)) - 32768;
         end
         run_win(md, r0, r1, 3, int'($urandom_range(0, 3)), 1'b0, 1'b0, a0, a1, as, e0, e1, es);
         if (md[1]) begin
            chk($sformatf("rnd%0d_dout0", i), a0, e0);
            chk($sformatf("rnd%0d_dout1", i), a1, e1);
            chk($sformatf("rnd%0d_sat", i), as, es);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end
endmodule
